// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the core's single memory port between the fetch stage (instruction
// reads) and the memory stage (loads/stores). At most one transaction is in
// flight at a time. Data requests win over fetch, but after MAX_DSTREAK
// consecutive data grants with fetch waiting, fetch is granted once.
//
// Handshake semantics (all three requester/memory interfaces):
//   A requester raises *_req with address/data and holds them stable until
//   it sees its *_gnt pulse; the grant is the transfer point. Responses are
//   single-cycle *_rvalid pulses with data valid only in that cycle. Towards
//   memory, mem_req is raised from registers and held with stable mem_*
//   fields until mem_gnt; mem_rvalid is expected one or more cycles later.
//
// Ports:
//   clk, nrst                  clock, synchronous active-low reset
//   if_req/if_addr/if_flush    fetch request, address, redirect (drop resp)
//   if_gnt/if_rvalid/if_rdata  fetch grant pulse, response pulse, read data
//   d_req/d_we/d_be/d_addr/d_wdata   data request fields
//   d_gnt/d_rvalid/d_rdata     data grant pulse, response pulse, read data
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   memory port request (latched)
//   mem_gnt/mem_rvalid/mem_rdata               memory port accept/response
//   fsm_state                  current FSM state (0 IDLE, 1 REQ, 2 WAIT)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                clk,
    input  logic                nrst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic [1:0]          fsm_state
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q;
    logic                  drop_q;
    logic [STREAK_W-1:0]   streak_q;

    logic                  lat_we_q;
    logic [BE_W-1:0]       lat_be_q;
    logic [ADDR_W-1:0]     lat_addr_q;
    logic [DATA_W-1:0]     lat_wdata_q;

    logic                  fetch_starved;
    logic                  grant_data;
    logic                  grant_fetch;

    // Fetch may only claim the port over a pending data request once the
    // data streak has saturated, and never while a redirect is flushing it.
    assign fetch_starved = if_req && !if_flush && (streak_q == STREAK_MAX);

    // ---------------------------------------------------------------------
    // Next-state and arbitration
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_req && !fetch_starved) begin
                    grant_data = 1'b1;
                end else if (if_req && !if_flush) begin
                    grant_fetch = 1'b1;
                end
                if (grant_data || grant_fetch) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs. mem_req depends only on registered state, so there is no
    // combinational path from the memory handshake back to the request.
    // ---------------------------------------------------------------------
    assign d_gnt     = grant_data;
    assign if_gnt    = grant_fetch;

    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = lat_we_q;
    assign mem_be    = lat_be_q;
    assign mem_addr  = lat_addr_q;
    assign mem_wdata = lat_wdata_q;

    assign d_rvalid  = (state_q == S_WAIT) && mem_rvalid && (owner_q == OWN_DATA);
    // A redirect in the response cycle itself also kills the fetch data.
    assign if_rvalid = (state_q == S_WAIT) && mem_rvalid && (owner_q == OWN_FETCH)
                       && !drop_q && !if_flush;

    assign d_rdata   = mem_rdata;
    assign if_rdata  = mem_rdata;

    assign fsm_state = state_q;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Request latch and owner. Fetches are always full-word reads.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            owner_q     <= OWN_DATA;
            lat_we_q    <= 1'b0;
            lat_be_q    <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else if (grant_data) begin
            owner_q     <= OWN_DATA;
            lat_we_q    <= d_we;
            lat_be_q    <= d_be;
            lat_addr_q  <= d_addr;
            lat_wdata_q <= d_wdata;
        end else if (grant_fetch) begin
            owner_q     <= OWN_FETCH;
            lat_we_q    <= 1'b0;
            lat_be_q    <= '1;
            lat_addr_q  <= if_addr;
            lat_wdata_q <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Data streak: counts data grants that happened while fetch was asking.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            streak_q <= '0;
        end else if (grant_data) begin
            if (!if_req) begin
                streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
        end else if (grant_fetch) begin
            streak_q <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Drop flag: a redirect while a fetch is in flight lets the memory
    // transaction finish but swallows its response. Clearing on IDLE entry
    // takes precedence so nothing leaks into the next transaction.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            drop_q <= 1'b0;
        end else if (state_d == S_IDLE) begin
            drop_q <= 1'b0;
        end else if ((state_q != S_IDLE) && (owner_q == OWN_FETCH) && if_flush) begin
            drop_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs are driven just after the
// falling edge, outputs are sampled 1 ns later (well before the next rising
// edge). Every expected response {owner, data} is pushed into exp_q when its
// request is granted and popped when an rvalid pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              nrst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        fsm_state;

  // scoreboard entry: {1 = fetch / 0 = data, read data}
  logic [DATA_W:0]   exp_q[$];
  int                checks = 0;
  int                errors = 0;

  bit                exp_d_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_DSTREAK (4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fsm_state  (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    #1;
  endtask

  // pops the scoreboard whenever a response pulse is present this cycle
  task automatic monitor();
    logic [DATA_W:0] e;
    if (d_rvalid || if_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_owner", {if_rvalid, d_rvalid}, e[DATA_W] ? 2'b10 : 2'b01);
        chk("resp_data", if_rvalid ? if_rdata : d_rdata, e[DATA_W-1:0]);
      end
    end
  endtask

  task automatic finish_cycle();
    monitor();
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    finish_cycle();
  endtask

  // one uncontended minimum-latency transaction: grant, REQ with same-cycle
  // mem_gnt, WAIT with same-cycle mem_rvalid
  task automatic simple_txn(input string tag, input bit fetch,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata);
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_addr = addr; d_we = 1'b0; d_be = '1;
    end
    sample();
    chk({tag, "_gnt"}, {if_gnt, d_gnt}, fetch ? 2'b10 : 2'b01);
    chk({tag, "_idle_mem_req"}, mem_req, 1'b0);
    exp_q.push_back({fetch, rdata});
    finish_cycle();
    if_req = 1'b0; d_req = 1'b0;
    mem_gnt = 1'b1;
    sample();
    chk({tag, "_mem_req"}, mem_req, 1'b1);
    chk({tag, "_mem_addr"}, mem_addr, addr);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    finish_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    sample();
    chk({tag, "_rvalid"}, {if_rvalid, d_rvalid}, fetch ? 2'b10 : 2'b01);
    finish_cycle();
    mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    chk({tag, "_back_idle"}, fsm_state, 2'd0);
    chk({tag, "_no_rvalid"}, {if_rvalid, d_rvalid}, 2'b00);
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [DATA_W-1:0] rd;

    nrst = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // ---- reset ----
    repeat (3) @(negedge clk);
    sample();
    chk("rst_state", fsm_state, 2'd0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_gnts", {if_gnt, d_gnt}, 2'b00);
    chk("rst_rvalids", {if_rvalid, d_rvalid}, 2'b00);
    chk("rst_mem_fields", {mem_we, mem_be, mem_addr, mem_wdata}, 69'd0);
    finish_cycle();
    nrst = 1'b1;
    step();

    // ---- single load ----
    simple_txn("load", 1'b0, 32'h100, 32'hDEADBEEF);
    finish_cycle();

    // ---- priority / starvation, both requesters held high ----
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b1010; d_addr = 32'h200; d_wdata = 32'h5555AAAA;
    if_req = 1'b1; if_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("arb_dgnt", d_gnt, exp_d_order[i]);
      chk("arb_ifgnt", if_gnt, !exp_d_order[i]);
      rd = $urandom;
      exp_q.push_back({!exp_d_order[i], rd});
      finish_cycle();
      mem_gnt = 1'b1;
      sample();
      chk("arb_no_gnt_in_req", {if_gnt, d_gnt}, 2'b00);
      chk("arb_addr", mem_addr, exp_d_order[i] ? 32'h200 : 32'h300);
      chk("arb_we", mem_we, exp_d_order[i]);
      chk("arb_be", mem_be, exp_d_order[i] ? 4'b1010 : 4'b1111);
      chk("arb_wdata", mem_wdata, exp_d_order[i] ? 32'h5555AAAA : 32'h0);
      finish_cycle();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
      step();
      mem_rvalid = 1'b0;
    end
    d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
    step();

    // ---- store with 3 wait states on mem_gnt ----
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h180; d_wdata = 32'h1234;
    sample();
    chk("st_gnt", d_gnt, 1'b1);
    rd = $urandom;
    exp_q.push_back({1'b0, rd});
    finish_cycle();
    // requester moves on; the port must keep the latched values
    d_req = 1'b0; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'hFFFF_0000; d_wdata = 32'hBAD0BAD0;
    for (int w = 0; w < 4; w++) begin
      mem_gnt = (w == 3);
      sample();
      chk("st_req_hold", {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
          {1'b1, 1'b1, 4'b0011, 32'h180, 32'h1234});
      finish_cycle();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    sample();
    chk("st_rvalid", d_rvalid, 1'b1);
    finish_cycle();
    mem_rvalid = 1'b0;
    sample();
    chk("st_single_pulse", d_rvalid, 1'b0);
    finish_cycle();

    // ---- flush during WAIT ----
    if_req = 1'b1; if_addr = 32'h40;
    sample();
    chk("fl_gnt", if_gnt, 1'b1);
    finish_cycle();
    if_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; if_flush = 1'b1;
    sample();
    chk("fl_wait_state", fsm_state, 2'd2);
    finish_cycle();
    if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
    sample();
    chk("fl_dropped", if_rvalid, 1'b0);
    finish_cycle();
    mem_rvalid = 1'b0;
    step();
    simple_txn("fl_next", 1'b1, 32'h80, 32'hCAFE0080);
    finish_cycle();

    // ---- flush in the same cycle as the response ----
    if_req = 1'b1; if_addr = 32'hC0;
    sample();
    chk("flr_gnt", if_gnt, 1'b1);
    finish_cycle();
    if_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; if_flush = 1'b1; mem_rdata = 32'h33334444;
    sample();
    chk("flr_dropped", if_rvalid, 1'b0);
    finish_cycle();
    mem_rvalid = 1'b0; if_flush = 1'b0;
    step();

    // ---- flush together with if_req in IDLE ----
    if_req = 1'b1; if_addr = 32'h140; if_flush = 1'b1;
    sample();
    chk("fli_no_gnt", {if_gnt, d_gnt}, 2'b00);
    finish_cycle();
    sample();
    chk("fli_still_idle", fsm_state, 2'd0);
    finish_cycle();
    if_flush = 1'b0;
    simple_txn("fli_fetch", 1'b1, 32'h140, 32'h5A5A0140);
    finish_cycle();
    // data is still granted while a flush blocks fetch
    if_req = 1'b1; if_flush = 1'b1;
    simple_txn("fli_data", 1'b0, 32'h144, 32'hA5A50144);
    finish_cycle();
    if_flush = 1'b0;

    // ---- reset during WAIT, then stray memory handshakes ----
    d_req = 1'b1; d_we = 1'b0; d_be = '1; d_addr = 32'h1C0;
    sample();
    chk("rw_gnt", d_gnt, 1'b1);
    finish_cycle();
    d_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; nrst = 1'b0;
    sample();
    chk("rw_in_wait", fsm_state, 2'd2);
    finish_cycle();
    nrst = 1'b1; mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFEEDFACE;
    sample();
    chk("rw_rvalids", {if_rvalid, d_rvalid}, 2'b00);
    chk("rw_state", fsm_state, 2'd0);
    chk("rw_mem_out", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 70'd0);
    finish_cycle();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    sample();
    chk("rw_stray_ignored", {fsm_state, mem_req}, 3'b000);
    finish_cycle();
    simple_txn("rw_after", 1'b0, 32'h1C4, 32'h0BADF00D);
    finish_cycle();

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
